// File: rtl/obstacle_scanner_pkg.sv
// ---------------------------------------------------------------------------
// obstacle_scanner_pkg
// Shared snake-game definitions: playfield size, tile codes, the coordinate
// pair used for generator queries and body segments, and the scan FSM states.
// ---------------------------------------------------------------------------
package obstacle_scanner_pkg;

  localparam int GRID_W = 14;  // playfield columns, x runs 1..GRID_W
  localparam int GRID_H = 10;  // playfield rows, y runs 1..GRID_H

  typedef enum logic [1:0] {
    TILE_EMPTY = 2'd0,
    TILE_OBST  = 2'd1,
    TILE_BODY  = 2'd2,
    TILE_HEAD  = 2'd3
  } tile_code_t;

  // Same bit layout as a body entry: {x[3:0], y[3:0]}.
  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } coord_t;

  localparam coord_t HOME = '{x: 4'd1, y: 4'd1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } scan_state_t;

endpackage

// File: rtl/snake_body_match.sv
// ---------------------------------------------------------------------------
// snake_body_match
// Purely combinational membership test of one coordinate against the snake
// body. Shared by the frame scanner and the collision logic.
//   body        : MAX_LENGTH x {x,y} segments, body[0] is the head
//   curr_length : number of valid entries (values above MAX_LENGTH clamp)
//   query       : coordinate under test
//   is_head     : query equals body[0] and the snake has at least one segment
//   is_body     : query equals some body[i], 1 <= i < curr_length
// ---------------------------------------------------------------------------
module snake_body_match
  import obstacle_scanner_pkg::*;
#(
  parameter int MAX_LENGTH = 50
) (
  input  logic [MAX_LENGTH-1:0][7:0] body,
  input  logic [7:0]                 curr_length,
  input  coord_t                     query,
  output logic                       is_head,
  output logic                       is_body
);

  logic [7:0] eff_len;

  always_comb begin
    eff_len = (curr_length > 8'(MAX_LENGTH)) ? 8'(MAX_LENGTH) : curr_length;
    is_head = (eff_len != 8'd0) && (body[0] == query);
    is_body = 1'b0;
    // Entries at or beyond the live length are stale and must not match.
    for (int i = 1; i < MAX_LENGTH; i++) begin
      if ((8'(i) < eff_len) && (body[i] == query)) begin
        is_body = 1'b1;
      end
    end
  end

endmodule

// File: rtl/obstacle_scanner.sv
// ---------------------------------------------------------------------------
// obstacle_scanner
// Walks the GRID_W x GRID_H playfield row-major once per start pulse, drives
// the query coordinate into the obstacle generator, merges the returned bit
// with snake-body membership and streams one tile per cell over valid/ready.
//
// Ports:
//   clk, nRst          clock, asynchronous active-low reset
//   start, abort       begin a frame (ignored while busy) / synchronous cancel
//   body, curr_length  snake segments {x,y} (body[0] = head) and live count
//   obstacle           generator answer for the current x/y (same cycle)
//   x, y               query coordinate to the generator
//   tile_valid/ready   output handshake; tile_code/tile_x/tile_y payload
//   busy               scan in progress
//   frame_done         one-cycle pulse after the final tile is accepted
//
// Optional feature, macro OBSTACLE_SCANNER_COUNT_CHECK_EN:
//   exp_count          expected number of obstacle cells in the frame
//   obs_seen           saturating count of captured cells with obstacle=1
//   count_mismatch     registered with frame_done: obs_seen != exp_count
// ---------------------------------------------------------------------------
module obstacle_scanner
  import obstacle_scanner_pkg::*;
#(
  parameter int MAX_LENGTH = 50
) (
  input  logic                       clk,
  input  logic                       nRst,
  input  logic                       start,
  input  logic                       abort,
  input  logic [MAX_LENGTH-1:0][7:0] body,
  input  logic [7:0]                 curr_length,
  input  logic                       obstacle,
  output logic [3:0]                 x,
  output logic [3:0]                 y,
  output logic                       tile_valid,
  input  logic                       tile_ready,
  output logic [1:0]                 tile_code,
  output logic [3:0]                 tile_x,
  output logic [3:0]                 tile_y,
  output logic                       busy,
`ifdef OBSTACLE_SCANNER_COUNT_CHECK_EN
  input  logic [3:0]                 exp_count,
  output logic [3:0]                 obs_seen,
  output logic                       count_mismatch,
`endif
  output logic                       frame_done
);

  scan_state_t state_q, state_d;
  coord_t      pos_q, pos_d;
  coord_t      tile_q, tile_d;
  tile_code_t  code_q, code_d;
  tile_code_t  cell_code;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        is_head, is_body;
  logic        load, last_cell;
`ifdef OBSTACLE_SCANNER_COUNT_CHECK_EN
  logic [3:0]  obs_q, obs_d;
  logic        mism_q, mism_d;
`endif

  snake_body_match #(.MAX_LENGTH(MAX_LENGTH)) u_body_match (
    .body       (body),
    .curr_length(curr_length),
    .query      (pos_q),
    .is_head    (is_head),
    .is_body    (is_body)
  );

  // Head outranks body, body outranks obstacle.
  always_comb begin
    if (is_head)       cell_code = TILE_HEAD;
    else if (is_body)  cell_code = TILE_BODY;
    else if (obstacle) cell_code = TILE_OBST;
    else               cell_code = TILE_EMPTY;
  end

  // The output register may be refilled when empty or when its tile leaves.
  assign load      = !valid_q || tile_ready;
  assign last_cell = (pos_q.x == 4'(GRID_W)) && (pos_q.y == 4'(GRID_H));

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    pos_d   = pos_q;
    tile_d  = tile_q;
    code_d  = code_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef OBSTACLE_SCANNER_COUNT_CHECK_EN
    obs_d   = obs_q;
    mism_d  = mism_q;
`endif

    case (state_q)
      ST_IDLE: begin
        pos_d = HOME;
        if (start) begin
          state_d = ST_SCAN;
          busy_d  = 1'b1;
`ifdef OBSTACLE_SCANNER_COUNT_CHECK_EN
          obs_d   = 4'd0;
          mism_d  = 1'b0;
`endif
        end
      end

      ST_SCAN: begin
        if (load) begin
          code_d  = cell_code;
          tile_d  = pos_q;
          valid_d = 1'b1;
`ifdef OBSTACLE_SCANNER_COUNT_CHECK_EN
          // Counts the raw generator bit, even when head/body outrank it.
          if (obstacle && (obs_q != 4'hF)) obs_d = obs_q + 4'd1;
`endif
          if (last_cell) begin
            state_d = ST_DRAIN;
            pos_d   = HOME;
          end else if (pos_q.x == 4'(GRID_W)) begin
            pos_d.x = 4'd1;
            pos_d.y = pos_q.y + 4'd1;
          end else begin
            pos_d.x = pos_q.x + 4'd1;
          end
        end
      end

      ST_DRAIN: begin
        if (valid_q && tile_ready) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
`ifdef OBSTACLE_SCANNER_COUNT_CHECK_EN
          mism_d  = (obs_q != exp_count);
`endif
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Abort overrides everything above, including a same-cycle start.
    if (abort) begin
      state_d = ST_IDLE;
      pos_d   = HOME;
      valid_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
`ifdef OBSTACLE_SCANNER_COUNT_CHECK_EN
      obs_d   = obs_q;
      mism_d  = 1'b0;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= ST_IDLE;
      pos_q   <= HOME;
      tile_q  <= '0;
      code_q  <= TILE_EMPTY;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef OBSTACLE_SCANNER_COUNT_CHECK_EN
      obs_q   <= 4'd0;
      mism_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      tile_q  <= tile_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef OBSTACLE_SCANNER_COUNT_CHECK_EN
      obs_q   <= obs_d;
      mism_q  <= mism_d;
`endif
    end
  end

  assign x          = pos_q.x;
  assign y          = pos_q.y;
  assign tile_valid = valid_q;
  assign tile_code  = code_q;
  assign tile_x     = tile_q.x;
  assign tile_y     = tile_q.y;
  assign busy       = busy_q;
  assign frame_done = done_q;
`ifdef OBSTACLE_SCANNER_COUNT_CHECK_EN
  assign obs_seen       = obs_q;
  assign count_mismatch = mism_q;
`endif

endmodule

// File: tb/tb_obstacle_scanner.sv
// ---------------------------------------------------------------------------
// tb_obstacle_scanner
// Self-checking bench for obstacle_scanner. The obstacle generator is a map
// indexed by the DUT's x/y; expected tiles come from a rule-level model of
// the playfield (head > body > obstacle > empty).
// ---------------------------------------------------------------------------
module tb_obstacle_scanner;
  import obstacle_scanner_pkg::*;

  localparam int ML      = 50;
  localparam int N_TILES = GRID_W * GRID_H;

  logic                clk = 1'b0;
  logic                nRst = 1'b0;
  logic                start = 1'b0;
  logic                abort = 1'b0;
  logic                tile_ready = 1'b0;
  logic                obstacle;
  logic [ML-1:0][7:0]  body = '0;
  logic [7:0]          curr_length = 8'd0;
  logic [3:0]          x, y, tile_x, tile_y;
  logic [1:0]          tile_code;
  logic                tile_valid, busy, frame_done;
`ifdef OBSTACLE_SCANNER_COUNT_CHECK_EN
  logic [3:0]          exp_count = 4'd0;
  logic [3:0]          obs_seen;
  logic                count_mismatch;
`endif

  bit obst_map [16][16];
  int n_checks = 0;
  int n_fail   = 0;
  int got [N_TILES];

  assign obstacle = obst_map[x][y];

  always #5 clk = ~clk;

  obstacle_scanner #(.MAX_LENGTH(ML)) dut (
    .clk           (clk),
    .nRst          (nRst),
    .start         (start),
    .abort         (abort),
    .body          (body),
    .curr_length   (curr_length),
    .obstacle      (obstacle),
    .x             (x),
    .y             (y),
    .tile_valid    (tile_valid),
    .tile_ready    (tile_ready),
    .tile_code     (tile_code),
    .tile_x        (tile_x),
    .tile_y        (tile_y),
    .busy          (busy),
`ifdef OBSTACLE_SCANNER_COUNT_CHECK_EN
    .exp_count     (exp_count),
    .obs_seen      (obs_seen),
    .count_mismatch(count_mismatch),
`endif
    .frame_done    (frame_done)
  );

  typedef struct {
    logic [7:0] len;
    logic [7:0] head, b1, b2, blast;
    int         ox, oy;
    int         qx, qy;
    logic [1:0] exp_code;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Playfield rule: head beats body beats obstacle beats empty.
  function automatic logic [1:0] model_code(input int cx, input int cy);
    int len;
    logic [7:0] key;
    len = (int'(curr_length) > ML) ? ML : int'(curr_length);
    key = {cx[3:0], cy[3:0]};
    if (len >= 1 && body[0] == key) return 2'd3;
    for (int i = 1; i < len; i++) if (body[i] == key) return 2'd2;
    if (obst_map[cx][cy]) return 2'd1;
    return 2'd0;
  endfunction

  task automatic clear_field();
    body = '0;
    curr_length = 8'd0;
    for (int i = 0; i < 16; i++) for (int j = 0; j < 16; j++) obst_map[i][j] = 1'b0;
  endtask

  // Runs one full frame from a start pulse, checking every accepted tile in
  // row-major order and payload stability under backpressure. Optionally
  // stalls 4 cycles while tile (bp_x,bp_y) is presented.
  task automatic run_frame(input int ready_pct, input bit bp_en, input int bp_x,
                           input int bp_y, output int cycles);
    int idx, cyc, stall, ex, ey;
    bit hold;
    logic [10:0] held;
    logic [3:0] fx, fy;
    idx = 0; cyc = 0; stall = 0; hold = 0; held = '0; fx = '0; fy = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("valid_after_start", tile_valid, 0);
    while (cyc < 3000) begin
      if (frame_done) break;
      if (cyc == 1) check("first_tile_valid", tile_valid, 1);
      if (bp_en && tile_valid && tile_x == bp_x[3:0] && tile_y == bp_y[3:0] && stall < 4) begin
        if (stall == 0) begin
          fx = x; fy = y;
        end else begin
          check("bp_x_frozen", x, fx);
          check("bp_y_frozen", y, fy);
        end
        tile_ready = 1'b0;
        stall++;
      end else begin
        tile_ready = ($urandom_range(99) < ready_pct);
      end
      if (hold) check("hold_payload", {tile_valid, tile_code, tile_x, tile_y}, held);
      if (tile_valid && tile_ready) begin
        if (idx < N_TILES) begin
          ex = idx % GRID_W + 1;
          ey = idx / GRID_W + 1;
          check("tile_x", tile_x, ex);
          check("tile_y", tile_y, ey);
          check("tile_code", tile_code, model_code(ex, ey));
          got[idx] = int'(tile_code);
        end else begin
          check("tile_overflow", idx, N_TILES - 1);
        end
        idx++;
      end
      hold = tile_valid && !tile_ready;
      held = {1'b1, tile_code, tile_x, tile_y};
      tick();
      cyc++;
    end
    check("frame_done_seen", frame_done, 1);
    check("tile_count", idx, N_TILES);
    check("busy_fell", busy, 0);
    check("valid_fell", tile_valid, 0);
`ifdef OBSTACLE_SCANNER_COUNT_CHECK_EN
    begin
      int cnt = 0;
      for (int i = 1; i <= GRID_W; i++) for (int j = 1; j <= GRID_H; j++) cnt += int'(obst_map[i][j]);
      if (cnt > 15) cnt = 15;
      check("obs_seen", obs_seen, cnt);
      check("count_mismatch", count_mismatch, (cnt != int'(exp_count)));
    end
`endif
    cycles = cyc;
    tick();
    check("frame_done_single", frame_done, 0);
    tile_ready = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [9];
    int cyc, guard;

    vecs[0] = '{8'd3,   8'h63, 8'h53, 8'h43, 8'h00, 5, 3, 5, 3, 2'd2};
    vecs[1] = '{8'd3,   8'h63, 8'h53, 8'h43, 8'h00, 5, 3, 6, 3, 2'd3};
    vecs[2] = '{8'd3,   8'h63, 8'h53, 8'h43, 8'h00, 5, 3, 4, 3, 2'd2};
    vecs[3] = '{8'd2,   8'h11, 8'h22, 8'h77, 8'h00, 0, 0, 7, 7, 2'd0};
    vecs[4] = '{8'd0,   8'h33, 8'h00, 8'h00, 8'h00, 3, 3, 3, 3, 2'd1};
    vecs[5] = '{8'd1,   8'h33, 8'h00, 8'h00, 8'h00, 3, 3, 3, 3, 2'd3};
    vecs[6] = '{8'd200, 8'h11, 8'h00, 8'h00, 8'h99, 0, 0, 9, 9, 2'd2};
    vecs[7] = '{8'd49,  8'h11, 8'h00, 8'h00, 8'h99, 0, 0, 9, 9, 2'd0};
    vecs[8] = '{8'd0,   8'h00, 8'h00, 8'h00, 8'h00, 14, 10, 14, 10, 2'd1};

    clear_field();
    repeat (2) @(posedge clk);
    #1;
    check("rst_x", x, 1);
    check("rst_y", y, 1);
    check("rst_valid", tile_valid, 0);
    check("rst_code", tile_code, 0);
    check("rst_tile_x", tile_x, 0);
    check("rst_tile_y", tile_y, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    nRst = 1'b1;
    tile_ready = 1'b1;
    tick();

    // Empty field, ready held high: frame_done right after edge k+141.
    run_frame(100, 1'b0, 0, 0, cyc);
    check("frame_latency", cyc, 141);

    // Directed cells.
    foreach (vecs[v]) begin
      clear_field();
      curr_length = vecs[v].len;
      body[0] = vecs[v].head;
      body[1] = vecs[v].b1;
      body[2] = vecs[v].b2;
      body[ML-1] = vecs[v].blast;
      obst_map[vecs[v].ox][vecs[v].oy] = 1'b1;
      run_frame(100, 1'b0, 0, 0, cyc);
      check($sformatf("vec%0d_code", v), got[(vecs[v].qy - 1) * GRID_W + vecs[v].qx - 1],
            {30'd0, vecs[v].exp_code});
    end

    // Backpressure: 4 stall cycles on tile (3,1).
    clear_field();
    run_frame(100, 1'b1, 3, 1, cyc);
    check("bp_latency", cyc, 145);

    // Start while busy, then abort at tile (9,4).
    tile_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (!(tile_valid && tile_x == 4'd9 && tile_y == 4'd4) && guard < 300) begin
      start = (tile_valid && tile_x == 4'd5 && tile_y == 4'd2);
      tick();
      guard++;
      if (start) begin
        start = 1'b0;
        check("busy_start_x", tile_x, 6);
        check("busy_start_y", tile_y, 2);
        check("busy_start_busy", busy, 1);
      end
    end
    check("abort_point_reached", (guard < 300), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_valid", tile_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_x", x, 1);
    check("abort_y", y, 1);
    check("abort_frame_done", frame_done, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_no_done", frame_done, 0);
    end
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check("abort_beats_start_busy", busy, 0);
    tick();
    check("abort_beats_start_valid", tile_valid, 0);
    run_frame(100, 1'b0, 0, 0, cyc);

    // Asynchronous reset mid-frame.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    check("pre_reset_busy", busy, 1);
    #2 nRst = 1'b0;
    #1;
    check("arst_x", x, 1);
    check("arst_y", y, 1);
    check("arst_valid", tile_valid, 0);
    check("arst_code", tile_code, 0);
    check("arst_tile_x", tile_x, 0);
    check("arst_tile_y", tile_y, 0);
    check("arst_busy", busy, 0);
    check("arst_frame_done", frame_done, 0);
    tick();
    nRst = 1'b1;
    tick();

    // Random fields with random backpressure.
    for (int r = 0; r < 4; r++) begin
      clear_field();
      curr_length = 8'($urandom_range(0, 60));
      for (int i = 0; i < ML; i++)
        body[i] = {4'($urandom_range(1, GRID_W)), 4'($urandom_range(1, GRID_H))};
      for (int i = 1; i <= GRID_W; i++)
        for (int j = 1; j <= GRID_H; j++) obst_map[i][j] = ($urandom_range(9) == 0);
`ifdef OBSTACLE_SCANNER_COUNT_CHECK_EN
      exp_count = 4'($urandom_range(0, 15));
`endif
      run_frame(70, 1'b0, 0, 0, cyc);
    end

`ifdef OBSTACLE_SCANNER_COUNT_CHECK_EN
    // Three obstacle cells, one hidden under the head.
    clear_field();
    curr_length = 8'd1;
    body[0] = 8'h22;
    obst_map[2][2] = 1'b1;
    obst_map[7][5] = 1'b1;
    obst_map[14][10] = 1'b1;
    exp_count = 4'd3;
    run_frame(100, 1'b0, 0, 0, cyc);
    check("feat_obs_seen_3", obs_seen, 3);
    check("feat_match", count_mismatch, 0);
    exp_count = 4'd4;
    run_frame(100, 1'b0, 0, 0, cyc);
    check("feat_mismatch", count_mismatch, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/obstacle_scanner.md
Name: obstacle_scanner

Overview:
- Read-side counterpart of the obstacle generator: walks the 14x10 playfield in row-major order and drives query coordinates x/y into the generator.
- Merges the returned obstacle bit with snake-body membership and streams one 2-bit tile code per cell to the display/renderer over a valid/ready handshake.
- One frame (140 tiles) is produced per start pulse.

Parameters:
- MAX_LENGTH, 50, number of body segment slots.
- GRID_W, 14, playfield columns; x runs 1..GRID_W.
- GRID_H, 10, playfield rows; y runs 1..GRID_H.

Ports:
- clk  in  1  system clock
- nRst  in  1  asynchronous active-low reset
- start  in  1  begin a frame scan; ignored while busy
- abort  in  1  synchronous cancel (game reset)
- body  in  MAX_LENGTH x 8  segment coordinates {x[3:0], y[3:0]}; body[0] is the head
- curr_length  in  8  number of valid body entries
- obstacle  in  1  obstacle bit returned by the generator for the current x/y (combinational, same cycle)
- x  out  4  query column to the generator
- y  out  4  query row to the generator
- tile_valid  out  1  tile payload valid
- tile_ready  in  1  consumer accepts the tile
- tile_code  out  2  0 empty, 1 obstacle, 2 body, 3 head
- tile_x  out  4  column of the presented tile
- tile_y  out  4  row of the presented tile
- busy  out  1  scan in progress
- frame_done  out  1  one-cycle pulse after the final tile is accepted

Behaviour:
- Reset values: x=1, y=1, tile_valid=0, tile_code=0, tile_x=0, tile_y=0, busy=0, frame_done=0, FSM=IDLE.
- FSM states: IDLE, SCAN, DRAIN.
- IDLE: x/y held at 1,1. start=1 -> SCAN, busy=1.
- SCAN, load condition (!tile_valid || tile_ready):
  - capture tile_code/tile_x/tile_y for the current x/y; set tile_valid=1.
  - advance x; at x==GRID_W, wrap x to 1 and increment y.
  - if the captured cell is (GRID_W,GRID_H): go to DRAIN; x/y return to 1,1.
- SCAN, no load: hold x/y and all tile outputs.
- DRAIN: on tile_valid && tile_ready, clear tile_valid, pulse frame_done, clear busy, go to IDLE.
- Tile code priority: head > body > obstacle > empty.
  - Head: {x,y}==body[0] and curr_length>=1.
  - Body: {x,y}==body[i] for some 1<=i<curr_length. Entries at i>=curr_length are ignored. curr_length>MAX_LENGTH is clamped to MAX_LENGTH.
- Handshake:
  - tile_code/x/y must not change while tile_valid=1 and tile_ready=0.
  - With tile_ready held high, throughput is one tile per clock.
- Latency: start sampled at edge k -> tile_valid high after edge k+1 with cell (1,1). With ready held high, the final tile is accepted at edge k+141 and frame_done is high for the following cycle.
- start during busy: ignored, no restart.
- start and abort in the same cycle: abort wins; stay in IDLE.
- abort in any state: next edge FSM=IDLE, tile_valid=0, busy=0, x=y=1, no frame_done.
- Async reset mid-frame returns all outputs to their reset values immediately.
- Body/obstacle inputs are sampled live at capture time; no frame snapshot is taken.

Optional Feature:
- Macro: OBSTACLE_SCANNER_COUNT_CHECK_EN.
- Enabled: adds input exp_count[3:0] and outputs obs_seen[3:0] and count_mismatch.
  - obs_seen counts captured tiles with obstacle=1, including tiles outranked by head/body. It saturates at 15, clears at start, and holds after the frame.
  - count_mismatch is registered alongside frame_done and holds until the next start or abort/reset: (obs_seen != exp_count).
- Disabled: these ports and the counter do not exist; behaviour is otherwise identical.

Decomposition:
- Shared snake package holds:
  - GRID_W/GRID_H constants;
  - tile_code enum (TILE_EMPTY, TILE_OBST, TILE_BODY, TILE_HEAD);
  - the coordinate typedef (4-bit x, 4-bit y pair).
- One sub-module: snake_body_match, purely combinational. It takes body, curr_length and a query coordinate and returns is_head and is_body. It is reusable by the collision logic.

Test Plan:
- Reset, then start with tile_ready=1, obstacle=0, curr_length=0 -> 140 tiles, all code 0. Order (1,1),(2,1)..(14,1),(1,2)..(14,10). frame_done is a single pulse after edge k+141; busy then falls.
- Obstacle driven 1 only when x=5,y=3; curr_length=3 with body {6,3},{5,3},{4,3} -> tile(5,3)=2 (body beats obstacle), tile(6,3)=3, tile(4,3)=2, all other tiles 0.
- Backpressure: tile_ready low for 4 cycles at tile (3,1) -> payload stable and x/y frozen; resumes with (4,1) next. Total tiles still 140, none duplicated or dropped.
- Stale body entry: curr_length=2, body[2]={7,7} -> tile(7,7)=0.
- abort asserted at tile (9,4), plus a start pulse while busy -> the busy start has no effect. After abort: tile_valid=0, busy=0, x=y=1 next cycle, no frame_done. A new start yields tile (1,1) first.
- With OBSTACLE_SCANNER_COUNT_CHECK_EN: 3 obstacle cells and exp_count=3 -> obs_seen=3, count_mismatch=0. With exp_count=4 -> count_mismatch=1.
